up_fifo_regs: RTL



---
 rtl/up_fifo_regs_pkg.sv | 17 +
 rtl/up_fifo_regs_fifo.sv | 50 +++++
 rtl/up_fifo_regs.sv | 124 ++++++++++++
 3 files changed

// File: rtl/up_fifo_regs_pkg.sv
// up_fifo_regs_pkg: register offsets and STATUS/CONTROL bit positions for up_fifo_regs
package up_fifo_regs_pkg;
  localparam logic [1:0] REG_RX_DATA = 2'd0;
  localparam logic [1:0] REG_TX_DATA = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;
  localparam int ST_RX_VALID    = 0;
  localparam int ST_RX_FULL     = 1;
  localparam int ST_TX_EMPTY    = 2;
  localparam int ST_TX_FULL     = 3;
  localparam int ST_RX_OVF      = 4;
  localparam int ST_TX_OVF      = 5;
  localparam int CTL_TX_FLUSH   = 0;
  localparam int CTL_RX_FLUSH   = 1;
  localparam int CTL_IRQ_RX_EN  = 4;
  localparam int CTL_IRQ_TXE_EN = 5;
endpackage

// File: rtl/up_fifo_regs_fifo.sv
// up_fifo_regs_fifo: first-word-fall-through FIFO with flush; count_o exists only with UP_FIFO_REGS_COUNT_EN
module up_fifo_regs_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [W-1:0]              din_i,
  output logic [W-1:0]              dout_o,
  output logic                      full_o,
  output logic                      empty_o,
`ifdef UP_FIFO_REGS_COUNT_EN
  output logic [$clog2(DEPTH):0]    count_o,
`endif
  output logic                      unused_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o   = cnt_q == (AW+1)'(DEPTH);
  assign empty_o  = cnt_q == '0;
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  // An empty FIFO presents zero so the stream and register views never leak stale data
  assign dout_o   = empty_o ? '0 : mem_q[rd_q];
  assign unused_o = 1'b0;
`ifdef UP_FIFO_REGS_COUNT_EN
  assign count_o  = cnt_q;
`endif
  always_comb cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= flush_i ? '0 : wr_q + AW'(do_push);
      rd_q  <= flush_i ? '0 : rd_q + AW'(do_pop);
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/up_fifo_regs.sv
// up_fifo_regs: uP register slave with TX/RX FIFOs, status, control and irq; UP_FIFO_REGS_COUNT_EN adds FIFO counts to STATUS[23:8]
module up_fifo_regs
  import up_fifo_regs_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     up_rreq,
  output logic                     up_rack,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [BUS_WIDTH*8-1:0]   up_rdata,
  input  logic                     up_wreq,
  output logic                     up_wack,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [BUS_WIDTH*8-1:0]   up_wdata,
  output logic [BUS_WIDTH*8-1:0]   m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic [BUS_WIDTH*8-1:0]   s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic                     irq
);
  localparam int DW   = BUS_WIDTH * 8;
  localparam int ALSB = $clog2(BUS_WIDTH);
  logic rack_q, wack_q, irq_q, irq_d;
  logic rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic irq_rx_en_q, irq_rx_en_d, irq_txe_en_q, irq_txe_en_d;
  logic [DW-1:0] rdata_q, rdata_d, status, control, rx_head;
  logic [1:0] roff, woff;
  logic rd_acc, wr_acc, wr_ctrl, wr_stat;
  logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic tx_unused, rx_unused, unused_ok;
`ifdef UP_FIFO_REGS_COUNT_EN
  logic [$clog2(FIFO_DEPTH):0] rx_count, tx_count;
`endif
  assign roff      = up_raddr[ALSB+1:ALSB];
  assign woff      = up_waddr[ALSB+1:ALSB];
  assign unused_ok = ^{up_raddr, up_waddr, tx_unused, rx_unused};
  // A request is taken only while its ack is low, so a held request is served every other cycle
  assign rd_acc    = up_rreq & ~rack_q;
  assign wr_acc    = up_wreq & ~wack_q;
  assign wr_ctrl   = wr_acc & (woff == REG_CONTROL);
  assign wr_stat   = wr_acc & (woff == REG_STATUS);
  assign tx_push   = wr_acc & (woff == REG_TX_DATA);
  assign tx_pop    = m_axis_tvalid & m_axis_tready;
  assign tx_flush  = wr_ctrl & up_wdata[CTL_TX_FLUSH];
  assign rx_push   = s_axis_tvalid & s_axis_tready;
  assign rx_pop    = rd_acc & (roff == REG_RX_DATA);
  assign rx_flush  = wr_ctrl & up_wdata[CTL_RX_FLUSH];
  assign m_axis_tvalid = ~tx_empty;
  assign s_axis_tready = ~rx_full;
  assign up_rack   = rack_q;
  assign up_wack   = wack_q;
  assign up_rdata  = rdata_q;
  assign irq       = irq_q;
  up_fifo_regs_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rstn(rstn), .push_i(tx_push), .pop_i(tx_pop), .flush_i(tx_flush),
    .din_i(up_wdata), .dout_o(m_axis_tdata), .full_o(tx_full), .empty_o(tx_empty),
`ifdef UP_FIFO_REGS_COUNT_EN
    .count_o(tx_count),
`endif
    .unused_o(tx_unused)
  );
  up_fifo_regs_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rstn(rstn), .push_i(rx_push), .pop_i(rx_pop), .flush_i(rx_flush),
    .din_i(s_axis_tdata), .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty),
`ifdef UP_FIFO_REGS_COUNT_EN
    .count_o(rx_count),
`endif
    .unused_o(rx_unused)
  );
  always_comb begin
    status = '0;
    status[ST_RX_VALID] = ~rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_OVF]   = rx_ovf_q;
    status[ST_TX_OVF]   = tx_ovf_q;
`ifdef UP_FIFO_REGS_COUNT_EN
    status[15:8]  = 8'(rx_count);
    status[23:16] = 8'(tx_count);
`endif
    control = '0;
    control[CTL_IRQ_RX_EN]  = irq_rx_en_q;
    control[CTL_IRQ_TXE_EN] = irq_txe_en_q;
    rdata_d = !rd_acc ? rdata_q :
              roff == REG_RX_DATA ? rx_head :
              roff == REG_STATUS  ? status :
              roff == REG_CONTROL ? control : '0;
    // Overflow set wins over a same-edge W1C clear so no event is lost
    rx_ovf_d = (s_axis_tvalid & rx_full) | (rx_ovf_q & ~(wr_stat & up_wdata[ST_RX_OVF]));
    tx_ovf_d = (tx_push & tx_full) | (tx_ovf_q & ~(wr_stat & up_wdata[ST_TX_OVF]));
    irq_rx_en_d  = wr_ctrl ? up_wdata[CTL_IRQ_RX_EN] : irq_rx_en_q;
    irq_txe_en_d = wr_ctrl ? up_wdata[CTL_IRQ_TXE_EN] : irq_txe_en_q;
    irq_d = (irq_rx_en_q & ~rx_empty) | (irq_txe_en_q & tx_empty);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rack_q       <= 1'b0;
      wack_q       <= 1'b0;
      rdata_q      <= '0;
      rx_ovf_q     <= 1'b0;
      tx_ovf_q     <= 1'b0;
      irq_rx_en_q  <= 1'b0;
      irq_txe_en_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      rack_q       <= rd_acc;
      wack_q       <= wr_acc;
      rdata_q      <= rdata_d;
      rx_ovf_q     <= rx_ovf_d;
      tx_ovf_q     <= tx_ovf_d;
      irq_rx_en_q  <= irq_rx_en_d;
      irq_txe_en_q <= irq_txe_en_d;
      irq_q        <= irq_d;
    end
  end
endmodule
